alarm_zone_ctrl: RTL and testbench

- Parametrised N-zone intrusion alarm controller; next generation of the single-door/single-window main state machine.
- Adds per-zone instant/delayed typing, zone bypass latched at arming, exit delay, entry delay, bad-key lockout count, siren auto-silence and per-zone alarm memory.
- Consumes KEY_STATUS from the existing code checker. Drives siren and status lines toward the serial status transmitter.

---
 rtl/alarm_pkg.sv | 25 ++
 rtl/alarm_zone_ctrl_timer.sv | 37 +++
 rtl/alarm_zone_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alarm_zone_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared encodings for the zone alarm controller and its neighbours
package alarm_pkg;

  // Main state encoding; the numeric values are also the STATE_OUT code
  // consumed by the serial status formatter.
  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_EXIT_DLY  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY_DLY = 3'd3,
    ST_ALARM     = 3'd4
  } state_e;

  // Code checker status values. Code 1 is unused and reads as "no key",
  // so bit 0 alone tells whether a key is currently being presented.
  localparam logic [1:0] KEY_OK    = 2'd0;
  localparam logic [1:0] KEY_ERROR = 2'd2;
  localparam logic [1:0] NO_KEY    = 2'd3;

  // STATE_OUT code for a given state.
  function automatic logic [2:0] state_code(input state_e s);
    return 3'(s);
  endfunction

endpackage

// File: rtl/alarm_zone_ctrl_timer.sv
// rtl/alarm_zone_ctrl_timer.sv - loadable down-counter shared by exit, entry and siren delays
module alarm_delay_timer #(
  parameter int TIMER_W = 18
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               busy,
  output logic               expired
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy    = (cnt_q != '0);
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/alarm_zone_ctrl.sv
// rtl/alarm_zone_ctrl.sv - N-zone intrusion alarm main state machine
module alarm_zone_ctrl
  import alarm_pkg::*;
#(
  parameter int                   NUM_ZONES    = 4,
  parameter logic [NUM_ZONES-1:0] DELAY_MASK   = 4'b0001,
  parameter int                   TIMER_W      = 18,
  parameter int                   EXIT_TICKS   = 150000,
  parameter int                   ENTRY_TICKS  = 150000,
  parameter int                   SIREN_TICKS  = 262143,
  parameter int                   MAX_BAD_KEYS = 3,
  localparam int                  BK_W         = $clog2(MAX_BAD_KEYS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_ZONES-1:0] SENSOR_IN,
  input  logic [NUM_ZONES-1:0] ZONE_BYPASS,
  input  logic [1:0]           KEY_STATUS,
  output logic                 SIREN_OUT,
  output logic                 ARMED_OUT,
  output logic [2:0]           STATE_OUT,
  output logic [NUM_ZONES-1:0] ALARM_ZONES,
  output logic [BK_W-1:0]      BAD_KEYS,
  output logic                 TIMER_BUSY
);

  localparam logic [TIMER_W-1:0] EXIT_LOAD  = TIMER_W'(EXIT_TICKS - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LOAD = TIMER_W'(ENTRY_TICKS - 1);
  localparam logic [TIMER_W-1:0] SIREN_LOAD = TIMER_W'(SIREN_TICKS - 1);
  localparam logic [BK_W-1:0]    BAD_MAX    = BK_W'(MAX_BAD_KEYS);
  localparam logic [BK_W-1:0]    BAD_LAST   = BK_W'(MAX_BAD_KEYS - 1);

  state_e               state_q, state_d;
  logic                 siren_q, siren_d;
  logic                 armed_q, armed_d;
  logic [NUM_ZONES-1:0] zones_q, zones_d;
  logic [NUM_ZONES-1:0] byp_q, byp_d;
  logic [NUM_ZONES-1:0] entry_q, entry_d;
  logic [BK_W-1:0]      bad_q, bad_d;
  logic                 key_none_q;

  logic [NUM_ZONES-1:0] eff, inst, dly, trig;
  logic                 ok_ev, bad_ev, bad_limit;
  logic                 tmr_load, tmr_busy, tmr_expired;
  logic [TIMER_W-1:0]   tmr_val;

  assign eff  = SENSOR_IN & ~byp_q;
  assign inst = eff & ~DELAY_MASK;
  assign dly  = eff & DELAY_MASK;

  // A key event is the first cycle a key is presented after "no key".
  assign ok_ev  = key_none_q && (KEY_STATUS == KEY_OK);
  assign bad_ev = key_none_q && (KEY_STATUS == KEY_ERROR);

  // Consecutive bad-key counter; hitting the limit outside ALARM forces ALARM.
  always_comb begin
    bad_d     = bad_q;
    bad_limit = 1'b0;
    if (ok_ev) begin
      bad_d = '0;
    end else if (bad_ev) begin
      if (bad_q >= BAD_LAST) begin
        if (state_q != ST_ALARM) begin
          bad_limit = 1'b1;
          bad_d     = '0;
        end else begin
          bad_d = BAD_MAX;
        end
      end else begin
        bad_d = bad_q + BK_W'(1);
      end
    end
  end

  // Next state: OK first, then the bad-key limit, then sensors and delays.
  always_comb begin
    state_d = state_q;
    byp_d   = byp_q;
    entry_d = entry_q;
    trig    = '0;
    if (ok_ev) begin
      if (state_q == ST_DISARMED) begin
        state_d = ST_EXIT_DLY;
        byp_d   = ZONE_BYPASS;
      end else begin
        state_d = ST_DISARMED;
      end
    end else if (bad_limit) begin
      state_d = ST_ALARM;
    end else begin
      case (state_q)
        ST_EXIT_DLY: begin
          if (|inst) begin
            state_d = ST_ALARM;
            trig    = inst;
          end else if (tmr_expired) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (|inst) begin
            state_d = ST_ALARM;
            trig    = inst;
          end else if (|dly) begin
            state_d = ST_ENTRY_DLY;
            entry_d = dly;
          end
        end
        ST_ENTRY_DLY: begin
          if (|inst) begin
            state_d = ST_ALARM;
            trig    = entry_q | inst;
          end else if (tmr_expired) begin
            state_d = ST_ALARM;
            trig    = entry_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs, zone memory and delay-timer loading.
  always_comb begin
    armed_d = (state_d != ST_DISARMED);
    siren_d = siren_q;
    if (state_d != ST_ALARM) begin
      siren_d = 1'b0;
    end else if (state_q != ST_ALARM) begin
      siren_d = 1'b1;
    end else if (tmr_expired) begin
      siren_d = 1'b0;
    end

    zones_d = zones_q;
    if (state_q == ST_DISARMED && state_d == ST_EXIT_DLY) begin
      zones_d = '0;
    end else begin
      if (state_q == ST_ALARM) zones_d = zones_d | eff;
      if (state_d == ST_ALARM && state_q != ST_ALARM) zones_d = zones_d | trig;
    end

    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_EXIT_DLY:  begin tmr_load = 1'b1; tmr_val = EXIT_LOAD;  end
        ST_ENTRY_DLY: begin tmr_load = 1'b1; tmr_val = ENTRY_LOAD; end
        ST_ALARM:     begin tmr_load = 1'b1; tmr_val = SIREN_LOAD; end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_DISARMED;
      siren_q    <= 1'b0;
      armed_q    <= 1'b0;
      zones_q    <= '0;
      byp_q      <= '0;
      entry_q    <= '0;
      bad_q      <= '0;
      key_none_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      siren_q    <= siren_d;
      armed_q    <= armed_d;
      zones_q    <= zones_d;
      byp_q      <= byp_d;
      entry_q    <= entry_d;
      bad_q      <= bad_d;
      key_none_q <= KEY_STATUS[0];
    end
  end

  alarm_delay_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .busy     (tmr_busy),
    .expired  (tmr_expired)
  );

  assign SIREN_OUT   = siren_q;
  assign ARMED_OUT   = armed_q;
  assign STATE_OUT   = state_code(state_q);
  assign ALARM_ZONES = zones_q;
  assign BAD_KEYS    = bad_q;
  assign TIMER_BUSY  = tmr_busy;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// tb/tb_alarm_zone_ctrl.sv - self-checking bench for alarm_zone_ctrl
module tb_alarm_zone_ctrl;

  localparam logic [1:0] K_OK = 2'd0;
  localparam logic [1:0] K_ER = 2'd2;
  localparam logic [1:0] K_NO = 2'd3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] SENSOR_IN = '0;
  logic [3:0] ZONE_BYPASS = '0;
  logic [1:0] KEY_STATUS = K_NO;
  logic       SIREN_OUT, ARMED_OUT, TIMER_BUSY;
  logic [2:0] STATE_OUT;
  logic [3:0] ALARM_ZONES;
  logic [1:0] BAD_KEYS;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] sens;
    logic [3:0] byp;
    logic [1:0] key;
    int         n;
    logic [2:0] st;
    logic       sir;
    logic       arm;
    logic [3:0] zn;
    logic [1:0] bad;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  alarm_zone_ctrl #(
    .NUM_ZONES    (4),
    .DELAY_MASK   (4'b0001),
    .TIMER_W      (8),
    .EXIT_TICKS   (8),
    .ENTRY_TICKS  (5),
    .SIREN_TICKS  (10),
    .MAX_BAD_KEYS (3)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .SENSOR_IN   (SENSOR_IN),
    .ZONE_BYPASS (ZONE_BYPASS),
    .KEY_STATUS  (KEY_STATUS),
    .SIREN_OUT   (SIREN_OUT),
    .ARMED_OUT   (ARMED_OUT),
    .STATE_OUT   (STATE_OUT),
    .ALARM_ZONES (ALARM_ZONES),
    .BAD_KEYS    (BAD_KEYS),
    .TIMER_BUSY  (TIMER_BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic [3:0] s, input logic [3:0] b, input logic [1:0] k,
                              input int n, input logic [2:0] st, input logic sir,
                              input logic [3:0] zn, input logic [1:0] bad);
    vec_t v;
    v.sens = s; v.byp = b; v.key = k; v.n = n;
    v.st = st; v.sir = sir; v.arm = (st != 3'd0); v.zn = zn; v.bad = bad;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge CLK);
    SENSOR_IN   = v.sens;
    ZONE_BYPASS = v.byp;
    KEY_STATUS  = v.key;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".state"}, 32'(STATE_OUT), 32'(e.st));
    chk({tag, ".siren"}, 32'(SIREN_OUT), 32'(e.sir));
    chk({tag, ".armed"}, 32'(ARMED_OUT), 32'(e.arm));
    chk({tag, ".zones"}, 32'(ALARM_ZONES), 32'(e.zn));
    chk({tag, ".bad"},   32'(BAD_KEYS), 32'(e.bad));
  endtask

  // Arming: one OK cycle, 7 more exit cycles, then ARMED.
  task automatic add_arm(input logic [3:0] byp);
    tbl.push_back(mk(4'b0000, byp,     K_OK, 1, 3'd1, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 7, 3'd1, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd2, 1'b0, 4'b0000, 2'd0));
  endtask

  initial begin
    // arm, then entry delay expiring into a self-silencing alarm
    add_arm(4'b0000);
    tbl.push_back(mk(4'b0001, 4'b0000, K_NO, 1, 3'd3, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 4, 3'd3, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd4, 1'b1, 4'b0001, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 9, 3'd4, 1'b1, 4'b0001, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 2, 3'd4, 1'b0, 4'b0001, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_OK, 1, 3'd0, 1'b0, 4'b0001, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd0, 1'b0, 4'b0001, 2'd0));
    // bypassed zone ignored, instant zone trips
    add_arm(4'b0100);
    tbl.push_back(mk(4'b0100, 4'b0000, K_NO, 3, 3'd2, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0010, 4'b0000, K_NO, 1, 3'd4, 1'b1, 4'b0010, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_OK, 1, 3'd0, 1'b0, 4'b0010, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd0, 1'b0, 4'b0010, 2'd0));
    // disarm on 3rd cycle of entry delay
    add_arm(4'b0000);
    tbl.push_back(mk(4'b0001, 4'b0000, K_NO, 1, 3'd3, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 2, 3'd3, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_OK, 1, 3'd0, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd0, 1'b0, 4'b0000, 2'd0));
    // bad keys; a held KEY_ERROR counts once
    add_arm(4'b0000);
    tbl.push_back(mk(4'b0000, 4'b0000, K_ER, 1, 3'd2, 1'b0, 4'b0000, 2'd1));
    tbl.push_back(mk(4'b0000, 4'b0000, K_ER, 2, 3'd2, 1'b0, 4'b0000, 2'd1));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd2, 1'b0, 4'b0000, 2'd1));
    tbl.push_back(mk(4'b0000, 4'b0000, K_ER, 1, 3'd2, 1'b0, 4'b0000, 2'd2));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd2, 1'b0, 4'b0000, 2'd2));
    tbl.push_back(mk(4'b0000, 4'b0000, K_ER, 1, 3'd4, 1'b1, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd4, 1'b1, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_OK, 1, 3'd0, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd0, 1'b0, 4'b0000, 2'd0));
    // OK beats an instant sensor in the same cycle
    add_arm(4'b0000);
    tbl.push_back(mk(4'b0010, 4'b0000, K_OK, 1, 3'd0, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, K_NO, 1, 3'd0, 1'b0, 4'b0000, 2'd0));

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.state", 32'(STATE_OUT), 32'd0);
    chk("rst.siren", 32'(SIREN_OUT), 32'd0);
    chk("rst.armed", 32'(ARMED_OUT), 32'd0);
    chk("rst.zones", 32'(ALARM_ZONES), 32'd0);
    chk("rst.bad",   32'(BAD_KEYS), 32'd0);
    chk("rst.busy",  32'(TIMER_BUSY), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        step(tbl[i], $sformatf("v%0d_%0d", i, j));
      end
    end

    // timer busy boundary and asynchronous reset mid-alarm
    step(mk(4'b0000, 4'b0000, K_OK, 1, 3'd1, 1'b0, 4'b0000, 2'd0), "h_arm");
    chk("h_busy_load", 32'(TIMER_BUSY), 32'd1);
    for (int j = 0; j < 7; j++) begin
      step(mk(4'b0000, 4'b0000, K_NO, 1, 3'd1, 1'b0, 4'b0000, 2'd0), $sformatf("h_exit%0d", j));
    end
    chk("h_busy_zero", 32'(TIMER_BUSY), 32'd0);
    step(mk(4'b0000, 4'b0000, K_NO, 1, 3'd2, 1'b0, 4'b0000, 2'd0), "h_armed");
    step(mk(4'b0010, 4'b0000, K_NO, 1, 3'd4, 1'b1, 4'b0010, 2'd0), "h_trip");
    chk("h_busy_siren", 32'(TIMER_BUSY), 32'd1);
    step(mk(4'b0000, 4'b0000, K_NO, 1, 3'd4, 1'b1, 4'b0010, 2'd0), "h_alarm");
    @(posedge CLK);
    #1;
    chk("h_siren_pre", 32'(SIREN_OUT), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("arst.siren", 32'(SIREN_OUT), 32'd0);
    chk("arst.state", 32'(STATE_OUT), 32'd0);
    chk("arst.armed", 32'(ARMED_OUT), 32'd0);
    chk("arst.zones", 32'(ALARM_ZONES), 32'd0);
    chk("arst.bad",   32'(BAD_KEYS), 32'd0);
    chk("arst.busy",  32'(TIMER_BUSY), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    step(mk(4'b0000, 4'b0000, K_NO, 1, 3'd0, 1'b0, 4'b0000, 2'd0), "h_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
